// File: rtl/rr_burst_sched_if.sv
// ---------------------------------------------------------------------------
// rr_burst_sched_if
//
// Bundle of the request/grant and engine-side signals of the round-robin
// burst scheduler.
//
//   req    : per-requester level request, bit i = requester i
//   len    : per-requester burst length, requester i at [i*LEN_W +: LEN_W];
//            a value of L asks for L+1 beats
//   rdy    : shared engine can take a beat this cycle
//   abort  : terminate the current burst early
//   gnt    : one-hot grant to the burst owner (registered)
//   gnt_id : binary index of the burst owner (registered)
//   start  : one-cycle pulse at burst start
//   step   : a beat is issued to the engine this cycle
//   done   : one-cycle pulse when the burst finishes (normal or aborted)
//   busy   : scheduler is not idle
//
// Modports:
//   master : requester/engine side (drives req, len, rdy, abort)
//   slave  : the scheduler itself
// ---------------------------------------------------------------------------
interface rr_burst_sched_if #(
    parameter int N     = 4,
    parameter int LEN_W = 4
);
    localparam int ID_W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]       req;
    logic [N*LEN_W-1:0] len;
    logic               rdy;
    logic               abort;
    logic [N-1:0]       gnt;
    logic [ID_W-1:0]    gnt_id;
    logic               start;
    logic               step;
    logic               done;
    logic               busy;

    modport master (
        output req, len, rdy, abort,
        input  gnt, gnt_id, start, step, done, busy
    );

    modport slave (
        input  req, len, rdy, abort,
        output gnt, gnt_id, start, step, done, busy
    );
endinterface

// File: rtl/rr_burst_sched.sv
// ---------------------------------------------------------------------------
// rr_burst_sched
//
// Round-robin scheduler that hands a shared engine to one of N requesters
// for a whole burst. A winner is picked in IDLE by searching upward from a
// rotating pointer; its length field is captured so later changes to req/len
// do not disturb the running burst. The burst then walks through
// GRANT (start pulse) -> RUN (one beat per rdy cycle, abortable) -> LAST,
// after which the pointer moves to the requester just past the owner.
//
// Ports:
//   clk   : clock, rising-edge
//   rst_n : asynchronous active-low reset
//   bus   : rr_burst_sched_if.slave (req, len, rdy, abort in;
//           gnt, gnt_id, start, step, done, busy out)
// ---------------------------------------------------------------------------
module rr_burst_sched #(
    parameter int N     = 4,
    parameter int LEN_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    rr_burst_sched_if.slave    bus
);
    localparam int ID_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RUN   = 2'd2,
        LAST  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [N-1:0]       gnt_q, gnt_d;
    logic [ID_W-1:0]    gnt_id_q, gnt_id_d;

    // Per-requester view of the packed length bus.
    logic [LEN_W-1:0]   len_arr [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_len
        assign len_arr[gi] = bus.len[gi*LEN_W +: LEN_W];
    end

    // -----------------------------------------------------------------------
    // Round-robin winner search: first requester at or above ptr_q, wrapping
    // past N-1 back to 0.
    // -----------------------------------------------------------------------
    logic               win_found;
    logic [ID_W-1:0]    win_idx;

    always_comb begin
        int idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!win_found && bus.req[idx]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(idx);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output logic.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        bus.start = 1'b0;
        bus.step  = 1'b0;
        bus.done  = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d          = GRANT;
                    gnt_d            = '0;
                    gnt_d[win_idx]   = 1'b1;
                    gnt_id_d         = win_idx;
                    // cnt holds the number of beats still to go after the
                    // current one, so the final beat is the one with cnt == 0.
                    cnt_d            = len_arr[win_idx];
                end
            end

            GRANT: begin
                // rdy/abort deliberately ignored: the engine sees start first.
                bus.start = 1'b1;
                state_d   = RUN;
            end

            RUN: begin
                if (bus.abort) begin
                    // Abort wins over rdy; no beat is issued this cycle.
                    bus.done = 1'b1;
                    state_d  = LAST;
                end else if (bus.rdy) begin
                    bus.step = 1'b1;
                    if (cnt_q == '0) begin
                        bus.done = 1'b1;
                        state_d  = LAST;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end

            LAST: begin
                state_d = IDLE;
                gnt_d   = '0;
                ptr_d   = (gnt_id_q == ID_W'(N - 1)) ? '0 : gnt_id_q + 1'b1;
            end

            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            gnt_id_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.gnt_id = gnt_id_q;
    assign bus.busy   = (state_q != IDLE);

endmodule

// File: tb/tb_rr_burst_sched.sv
// ---------------------------------------------------------------------------
// tb_rr_burst_sched
//
// Drives rr_burst_sched through a set of directed bursts (single burst,
// round-robin rotation, back-pressure, abort, reset mid-burst, maximum
// length with pointer wrap) followed by randomized traffic, and compares
// every cycle against a burst-level reference model.
// ---------------------------------------------------------------------------
module tb_rr_burst_sched;
    localparam int N     = 4;
    localparam int LEN_W = 4;
    localparam int LW    = N * LEN_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    rr_burst_sched_if #(.N(N), .LEN_W(LEN_W)) bus ();

    rr_burst_sched #(.N(N), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (burst level) ----------------
    // phase: 0 idle, 1 start cycle, 2 beat cycles, 3 closing cycle
    int m_phase, m_owner, m_left, m_ptr, m_beats;

    function automatic void model_reset();
        m_phase = 0;
        m_owner = 0;
        m_left  = 0;
        m_ptr   = 0;
        m_beats = 0;
    endfunction

    function automatic void model_advance(input logic [N-1:0] r, input logic [LW-1:0] l,
                                          input logic rd, input logic ab);
        case (m_phase)
            0: if (r != '0) begin
                for (int k = 0; k < N; k++) begin
                    int i = (m_ptr + k) % N;
                    if (r[i]) begin
                        m_owner = i;
                        break;
                    end
                end
                m_left  = int'((l >> (m_owner * LEN_W)) & ((1 << LEN_W) - 1)) + 1;
                m_beats = 0;
                m_phase = 1;
            end
            1: m_phase = 2;
            2: begin
                if (ab) begin
                    $display("burst owner=%0d beats=%0d aborted", m_owner, m_beats);
                    m_phase = 3;
                end else if (rd) begin
                    m_beats++;
                    m_left--;
                    if (m_left == 0) begin
                        $display("burst owner=%0d beats=%0d complete", m_owner, m_beats);
                        m_phase = 3;
                    end
                end
            end
            default: begin
                m_ptr   = (m_owner + 1) % N;
                m_phase = 0;
            end
        endcase
    endfunction

    // ---------------- DUT observations ----------------
    int cyc = 0;
    int dut_steps, dut_last_steps, dut_owner, done_cnt;
    logic [N-1:0] dut_gnt_at_start;
    int start_ids[$];
    int start_cyc[$];

    task automatic cycle(input logic [N-1:0] r, input logic [LW-1:0] l,
                         input logic rd, input logic ab);
        logic exp_step, exp_done;
        @(negedge clk);
        bus.req   = r;
        bus.len   = l;
        bus.rdy   = rd;
        bus.abort = ab;
        #1;
        if (!rst_n) model_reset();
        exp_step = (m_phase == 2) && rd && !ab;
        exp_done = (m_phase == 2) && (ab || (rd && m_left == 1));
        check_val("busy",  32'(bus.busy),  32'(m_phase != 0));
        check_val("start", 32'(bus.start), 32'(m_phase == 1));
        check_val("step",  32'(bus.step),  32'(exp_step));
        check_val("done",  32'(bus.done),  32'(exp_done));
        check_val("gnt",   32'(bus.gnt),   (m_phase != 0) ? (32'd1 << m_owner) : 32'd0);
        if (m_phase != 0) check_val("gnt_id", 32'(bus.gnt_id), 32'(m_owner));
        if (bus.start) begin
            dut_steps        = 0;
            dut_owner        = int'(bus.gnt_id);
            dut_gnt_at_start = bus.gnt;
            start_ids.push_back(int'(bus.gnt_id));
            start_cyc.push_back(cyc);
        end
        if (bus.step) dut_steps++;
        if (bus.done) begin
            dut_last_steps = dut_steps;
            done_cnt++;
        end
        if (rst_n) model_advance(r, l, rd, ab);
        cyc++;
    endtask

    // Reset asserted asynchronously between clock edges, with rdy high so a
    // live RUN state would otherwise show a step.
    task automatic async_reset();
        @(posedge clk);
        #2;
        bus.rdy   = 1'b1;
        bus.abort = 1'b0;
        rst_n     = 1'b0;
        #1;
        check_val("rst_busy",   32'(bus.busy),   32'd0);
        check_val("rst_gnt",    32'(bus.gnt),    32'd0);
        check_val("rst_gnt_id", 32'(bus.gnt_id), 32'd0);
        check_val("rst_start",  32'(bus.start),  32'd0);
        check_val("rst_step",   32'(bus.step),   32'd0);
        check_val("rst_done",   32'(bus.done),   32'd0);
        model_reset();
        cycle('0, '0, 1'b1, 1'b0);
        cycle('0, '0, 1'b1, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        int done_before;
        logic [N-1:0]  r;
        logic [LW-1:0] l;

        bus.req = '0; bus.len = '0; bus.rdy = 1'b0; bus.abort = 1'b0;
        dut_steps = 0; dut_last_steps = -1; dut_owner = -1; done_cnt = 0;
        dut_gnt_at_start = '0;
        model_reset();

        // Reset state.
        #1;
        check_val("init_busy", 32'(bus.busy), 32'd0);
        check_val("init_gnt",  32'(bus.gnt),  32'd0);
        cycle('0, '0, 1'b0, 1'b0);
        cycle('0, '0, 1'b0, 1'b0);
        rst_n = 1'b1;
        cycle('0, '0, 1'b0, 1'b0);

        // Single burst: requester 1, len 3 -> 4 beats.
        cycle(4'b0010, 16'h0030, 1'b1, 1'b0);
        repeat (8) cycle('0, 16'h0030, 1'b1, 1'b0);
        check_val("single_owner", 32'(dut_owner), 32'd1);
        check_val("single_gnt",   32'(dut_gnt_at_start), 32'b0010);
        check_val("single_steps", 32'(dut_last_steps), 32'd4);

        // Back-pressure: requester 2, len 2, rdy 1,0,0,1,0,1 in RUN.
        cycle(4'b0100, 16'h0200, 1'b1, 1'b0);
        cycle('0, 16'h0200, 1'b0, 1'b0);
        cycle('0, 16'h0200, 1'b1, 1'b0);
        cycle('0, 16'h0200, 1'b0, 1'b0);
        cycle('0, 16'h0200, 1'b0, 1'b0);
        cycle('0, 16'h0200, 1'b1, 1'b0);
        cycle('0, 16'h0200, 1'b0, 1'b0);
        cycle('0, 16'h0200, 1'b1, 1'b0);
        repeat (2) cycle('0, '0, 1'b1, 1'b0);
        check_val("bp_steps", 32'(dut_last_steps), 32'd3);

        // Abort: pointer is at 3, requester 2 wins, abort on third RUN cycle.
        cycle(4'b0100, 16'h0700, 1'b1, 1'b0);
        cycle('0, 16'h0700, 1'b1, 1'b1);
        cycle('0, 16'h0700, 1'b1, 1'b0);
        cycle('0, 16'h0700, 1'b1, 1'b0);
        cycle('0, 16'h0700, 1'b1, 1'b1);
        repeat (2) cycle('0, '0, 1'b1, 1'b1);
        check_val("abort_owner", 32'(dut_owner), 32'd2);
        check_val("abort_steps", 32'(dut_last_steps), 32'd2);
        cycle(4'b1111, '0, 1'b1, 1'b0);
        repeat (5) cycle('0, '0, 1'b1, 1'b0);
        check_val("abort_ptr_next", 32'(dut_owner), 32'd3);

        // Max length: requester 3 alone, len F -> 16 beats, pointer wraps.
        cycle(4'b1000, 16'hF000, 1'b1, 1'b0);
        repeat (20) cycle('0, 16'hF000, 1'b1, 1'b0);
        check_val("max_owner", 32'(dut_owner), 32'd3);
        check_val("max_steps", 32'(dut_last_steps), 32'd16);
        cycle(4'b1111, '0, 1'b1, 1'b0);
        repeat (5) cycle('0, '0, 1'b1, 1'b0);
        check_val("wrap_owner", 32'(dut_owner), 32'd0);

        // Round-robin rotation after a fresh reset.
        async_reset();
        start_ids.delete();
        start_cyc.delete();
        repeat (20) cycle(4'b1111, '0, 1'b1, 1'b0);
        check_val("rr_count", 32'(start_ids.size() >= 5), 32'd1);
        if (start_ids.size() >= 5) begin
            for (int k = 0; k < 5; k++) begin
                check_val("rr_order", 32'(start_ids[k]), 32'(k % N));
                if (k > 0) check_val("rr_spacing", 32'(start_cyc[k] - start_cyc[k-1]), 32'd4);
            end
        end

        // Reset mid-burst: requester 2 with cnt 5 stalled in RUN.
        cycle(4'b0100, 16'h0500, 1'b0, 1'b0);
        cycle('0, 16'h0500, 1'b0, 1'b0);
        cycle('0, 16'h0500, 1'b0, 1'b0);
        cycle('0, 16'h0500, 1'b0, 1'b0);
        done_before = done_cnt;
        async_reset();
        check_val("rst_no_done", 32'(done_cnt), 32'(done_before));
        cycle(4'b1001, '0, 1'b1, 1'b0);
        repeat (4) cycle('0, '0, 1'b1, 1'b0);
        check_val("rst_restart_owner", 32'(dut_owner), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 399) == 0) async_reset();
            r = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            l = LW'($urandom);
            cycle(r, l, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rr_burst_sched.md
RR_BURST_SCHED -- requirements
Module: rr_burst_sched

Interface
REQ-001 Parameter N, default 4, number of requesters (2..8).
REQ-002 Parameter LEN_W, default 4, burst-length field width per requester.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  N  per-requester burst request, level, bit i = requester i.
REQ-006 len  input  N*LEN_W  per-requester length field, requester i at bits [i*LEN_W +: LEN_W]; value L means L+1 beats.
REQ-007 rdy  input  1  shared engine accepts a beat this cycle.
REQ-008 abort  input  1  terminate current burst early.
REQ-009 gnt  output  N  registered one-hot grant to the burst owner.
REQ-010 gnt_id  output  clog2(N)  registered binary index of the burst owner.
REQ-011 start  output  1  one-cycle pulse, engine burst start.
REQ-012 step  output  1  beat issued to engine this cycle.
REQ-013 done  output  1  one-cycle pulse, burst finished (normal or aborted).
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, GRANT, RUN, LAST; illegal encodings SHALL go to IDLE next cycle.
REQ-016 IDLE: if req != 0, SHALL pick the winner by round-robin search starting at pointer ptr, upward with wrap at N-1; load gnt, gnt_id and beat counter cnt = winner's len field; go to GRANT. Otherwise stay in IDLE.
REQ-017 GRANT: start SHALL be 1 for exactly this one cycle; unconditional transition to RUN; rdy and abort are ignored in this state.
REQ-018 RUN: step SHALL equal rdy && !abort (combinational).
REQ-019 RUN: on a step cycle with cnt != 0, cnt SHALL decrement by 1 and the FSM SHALL stay in RUN.
REQ-020 RUN: on a step cycle with cnt == 0 (final beat), done SHALL be 1 in that same cycle and the next state SHALL be LAST.
REQ-021 RUN: rdy=0 and abort=0 SHALL hold state and cnt; step=0.
REQ-022 RUN: abort=1 SHALL take priority over rdy: step=0, done=1 that cycle, next state LAST, remaining beats discarded.
REQ-023 Total steps for an unaborted burst SHALL equal len+1 (1..2^LEN_W).
REQ-024 LAST: one cycle; on exit gnt SHALL clear to 0 and ptr SHALL become (gnt_id+1) mod N; next state IDLE.
REQ-025 gnt and gnt_id SHALL hold stable from GRANT entry through the LAST cycle inclusive.
REQ-026 Changes on req and len of any requester after winner selection SHALL NOT affect the current burst; deasserting the owner's req mid-burst does not end it.
REQ-027 abort in IDLE, GRANT or LAST SHALL have no effect.
REQ-028 Minimum spacing between consecutive start pulses SHALL be 4 cycles (GRANT, RUN with one beat, LAST, IDLE).
REQ-029 start, step and done SHALL be 0 in IDLE and LAST; done and start never assert in the same cycle.

Reset
REQ-030 rst_n low SHALL asynchronously force state=IDLE, ptr=0, cnt=0, gnt=0, gnt_id=0; therefore start=step=done=busy=0.
REQ-031 Reset asserted mid-burst SHALL abandon the burst without a done pulse; after release, arbitration restarts at requester 0.

Verification
REQ-032 Single burst: req=4'b0010, len[1]=3, rdy=1 constant -> gnt=4'b0010 and gnt_id=1 during GRANT through LAST, start pulses 1 cycle, 4 step cycles, done on the 4th step, busy low after LAST.
REQ-033 Round-robin: req=4'b1111 held, all len=0 -> grant order 0,1,2,3,0, with start pulses 4 cycles apart.
REQ-034 Back-pressure: len=2, rdy pattern 1,0,0,1,0,1 in RUN -> step only on the three rdy=1 cycles, done on the third; cnt held while rdy=0.
REQ-035 Abort: len=7, abort=1 on the third RUN cycle with rdy=1 -> 2 steps total, done=1 and step=0 in the abort cycle, then LAST, IDLE; ptr advances past the owner.
REQ-036 Reset mid-burst: rst_n low during RUN with cnt=5 -> all outputs 0 immediately, no done; after release with req=4'b1000|4'b0001, requester 0 wins first.
REQ-037 Max length and wrap: len=4'hF with N=4, owner 3 -> 16 steps, then ptr wraps to 0.
